// File: rtl/vending_pkg.sv
// vending_pkg: key codes, coin values and state encoding shared across the vending machine
package vending_pkg;
   localparam logic [7:0] KEY_NICKEL  = 8'h6E;
   localparam logic [7:0] KEY_DIME    = 8'h64;
   localparam logic [7:0] KEY_QUARTER = 8'h71;
   localparam logic [7:0] KEY_ITEM1   = 8'h31;
   localparam logic [7:0] KEY_ITEM2   = 8'h32;
   localparam logic [7:0] KEY_ITEM3   = 8'h33;
   localparam logic [7:0] KEY_ITEM4   = 8'h34;
   localparam logic [7:0] KEY_CANCEL  = 8'h63;
   localparam logic [7:0] VAL_NICKEL  = 8'd5;
   localparam logic [7:0] VAL_DIME    = 8'd10;
   localparam logic [7:0] VAL_QUARTER = 8'd25;
   typedef enum logic [1:0] {ST_IDLE, ST_VEND, ST_REFUND} state_e;
   function automatic logic [7:0] coin_value(input logic [7:0] key);
      return key == KEY_NICKEL  ? VAL_NICKEL  :
             key == KEY_DIME    ? VAL_DIME    :
             key == KEY_QUARTER ? VAL_QUARTER : 8'd0;
   endfunction
endpackage

// File: rtl/vending_key_controller_hold_timer.sv
// hold_timer: counts HOLD_CYCLES cycles from a start strobe and flags the last one
module hold_timer #(
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic done
);
   localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
   logic running_q, running_d;
   logic [CW-1:0] count_q, count_d;
   assign done = running_q && count_q == LAST;
   // a fresh start restarts the count; the counter rests at zero when idle
   always_comb begin
      running_d = start | (running_q & ~done);
      count_d   = (start | done | ~running_q) ? '0 : count_q + 1'b1;
   end
   // timer state, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         running_q <= 1'b0;
         count_q   <= '0;
      end else begin
         running_q <= running_d;
         count_q   <= count_d;
      end
   end
endmodule

// File: rtl/vending_key_controller.sv
// vending_key_controller: turns received ASCII keys into credit, vend and refund actions
module vending_key_controller
   import vending_pkg::*;
#(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int HOLD_SECONDS = 1,
   parameter int HOLD_CYCLES  = CLK_FREQ * HOLD_SECONDS,
   parameter int PRICE_1      = 50,
   parameter int PRICE_2      = 75,
   parameter int PRICE_3      = 100,
   parameter int PRICE_4      = 125,
   parameter int MAX_CREDIT   = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] credit,
   output logic       vend_led,
   output logic [1:0] vend_item,
   output logic       refund_led,
   output logic [7:0] change,
   output logic       busy,
   output logic       coin_reject,
   output logic       err_insufficient
);
   state_e state_q, state_d;
   logic [7:0] credit_q, credit_d, change_q, change_d;
   logic [1:0] vend_item_q, vend_item_d;
   logic vend_led_q, vend_led_d, refund_led_q, refund_led_d, busy_q, busy_d;
   logic coin_reject_q, coin_reject_d, err_q, err_d;
   logic [7:0] coin_val, price;
   logic [8:0] sum;
   logic [1:0] item;
   logic accept, is_coin, is_item, is_cancel, can_vend, start, done;
   assign accept    = rx_valid && state_q == ST_IDLE;
   assign coin_val  = coin_value(rx_data);
   assign is_coin   = coin_val != 8'd0;
   assign is_item   = rx_data >= KEY_ITEM1 && rx_data <= KEY_ITEM4;
   assign is_cancel = rx_data == KEY_CANCEL;
   assign item      = rx_data[1:0] - 2'd1;
   assign price     = item == 2'd0 ? 8'(PRICE_1) : item == 2'd1 ? 8'(PRICE_2) :
                      item == 2'd2 ? 8'(PRICE_3) : 8'(PRICE_4);
   assign sum       = {1'b0, credit_q} + {1'b0, coin_val};
   assign can_vend  = credit_q >= price;
   assign start     = state_q == ST_IDLE && state_d != ST_IDLE;
   hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .done  (done)
   );
   // state and registered outputs, aborted asynchronously by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         credit_q      <= '0;
         change_q      <= '0;
         vend_item_q   <= '0;
         vend_led_q    <= 1'b0;
         refund_led_q  <= 1'b0;
         busy_q        <= 1'b0;
         coin_reject_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         change_q      <= change_d;
         vend_item_q   <= vend_item_d;
         vend_led_q    <= vend_led_d;
         refund_led_q  <= refund_led_d;
         busy_q        <= busy_d;
         coin_reject_q <= coin_reject_d;
         err_q         <= err_d;
      end
   end
   // leave IDLE on an affordable select or a cancel with credit; return when the hold expires
   always_comb begin
      state_d = state_q;
      if (accept && is_item && can_vend) state_d = ST_VEND;
      else if (accept && is_cancel && credit_q != 8'd0) state_d = ST_REFUND;
      else if (state_q != ST_IDLE && done) state_d = ST_IDLE;
   end
   // credit bookkeeping and indications; bytes arriving while busy never reach here
   always_comb begin
      credit_d      = credit_q;
      change_d      = change_q;
      vend_item_d   = vend_item_q;
      vend_led_d    = vend_led_q;
      refund_led_d  = refund_led_q;
      coin_reject_d = 1'b0;
      err_d         = 1'b0;
      busy_d        = state_d != ST_IDLE;
      if (accept && is_coin) begin
         credit_d      = sum <= 9'(MAX_CREDIT) ? sum[7:0] : credit_q;
         coin_reject_d = sum > 9'(MAX_CREDIT);
      end else if (accept && is_item) begin
         err_d = ~can_vend;
         if (can_vend) begin
            change_d    = credit_q - price;
            credit_d    = '0;
            vend_item_d = item;
            vend_led_d  = 1'b1;
         end
      end else if (accept && is_cancel && credit_q != 8'd0) begin
         change_d     = credit_q;
         credit_d     = '0;
         refund_led_d = 1'b1;
      end else if (state_q != ST_IDLE && done) begin
         change_d     = '0;
         vend_item_d  = '0;
         vend_led_d   = 1'b0;
         refund_led_d = 1'b0;
      end
   end
   assign credit           = credit_q;
   assign change           = change_q;
   assign vend_item        = vend_item_q;
   assign vend_led         = vend_led_q;
   assign refund_led       = refund_led_q;
   assign busy             = busy_q;
   assign coin_reject      = coin_reject_q;
   assign err_insufficient = err_q;
endmodule
